// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory bus arbiter: FSM states and bus-side structs.
package cache_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_D = 2'd1,
        OWN_I = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              req;
        logic              wen;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic              wlast;
    } mem_req_t;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              addr_ok;
        logic              data_ok;
    } mem_rsp_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// One SRAM-like bus link: request side from master, response side from slave.
interface cache_mem_arbiter_if;
    import cache_pkg::*;

    mem_req_t rq;
    mem_rsp_t rsp;

    modport master (output rq, input rsp);
    modport slave  (input rq, output rsp);
endinterface

// File: rtl/cache_mem_arbiter_burst_beat_counter.sv
// Saturating addr/data beat counters for one burst; done fires on the final data beat.
module burst_beat_counter #(
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic addr_inc,
    input  logic data_inc,
    output logic addr_room,
    output logic done
);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN);

    logic [CW-1:0] addr_cnt;
    logic [CW-1:0] data_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt <= '0;
            data_cnt <= '0;
        end else if (clr) begin
            addr_cnt <= '0;
            data_cnt <= '0;
        end else begin
            if (addr_inc && addr_cnt != LAST) addr_cnt <= addr_cnt + CW'(1);
            if (data_inc && data_cnt != LAST) data_cnt <= data_cnt + CW'(1);
        end
    end

    assign addr_room = addr_cnt < LAST;
    assign done      = data_inc && (data_cnt == LAST - CW'(1));
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared memory bus between the D and I cache engines, one burst per grant.
// Build option: CACHE_ARB_RR_EN selects round-robin; otherwise fixed priority D over I.
//
// state | meaning
// IDLE  | bus quiet, grant decided from current requests
// OWN_D | D port muxed onto the bus until its last data beat
// OWN_I | I port muxed onto the bus until its last data beat
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input logic                  clk,
    input logic                  reset,
    cache_mem_arbiter_if.slave   d_port,
    cache_mem_arbiter_if.slave   i_port,
    cache_mem_arbiter_if.master  mem
);
    arb_state_t state;
    arb_state_t state_nxt;
    mem_req_t   owner_rq;
    mem_req_t   bus_rq;
    logic       pick_d;
    logic       addr_room;
    logic       done;
    logic       addr_inc;
    logic       data_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

`ifdef CACHE_ARB_RR_EN
    // 1 = D owned last; reset value points at I so D wins the first tie.
    logic last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= 1'b0;
        else if (state == IDLE && state_nxt != IDLE)
            last_grant <= (state_nxt == OWN_D);
    end

    assign pick_d = d_port.rq.req && (!i_port.rq.req || !last_grant);
`else
    assign pick_d = d_port.rq.req;
`endif

    always_comb begin
        state_nxt = state;
        owner_rq  = '0;
        case (state)
            IDLE: begin
                if (pick_d)              state_nxt = OWN_D;
                else if (i_port.rq.req)  state_nxt = OWN_I;
            end
            OWN_D: begin
                owner_rq = d_port.rq;
                if (done) state_nxt = IDLE;
            end
            OWN_I: begin
                owner_rq = i_port.rq;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bus_rq     = owner_rq;
        bus_rq.req = owner_rq.req && addr_room;
    end

    assign mem.rq = bus_rq;

    // Data beats outside a burst are a bridge protocol error and are dropped here.
    assign addr_inc = bus_rq.req && mem.rsp.addr_ok;
    assign data_inc = mem.rsp.data_ok && (state != IDLE);

    burst_beat_counter #(.BURST_LEN(BURST_LEN)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (done),
        .addr_inc  (addr_inc),
        .data_inc  (data_inc),
        .addr_room (addr_room),
        .done      (done)
    );

    assign d_port.rsp.rdata   = mem.rsp.rdata;
    assign d_port.rsp.addr_ok = (state == OWN_D) && addr_inc;
    assign d_port.rsp.data_ok = (state == OWN_D) && mem.rsp.data_ok;

    assign i_port.rsp.rdata   = mem.rsp.rdata;
    assign i_port.rsp.addr_ok = (state == OWN_I) && addr_inc;
    assign i_port.rsp.data_ok = (state == OWN_I) && mem.rsp.data_ok;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed vector bench for cache_mem_arbiter with BURST_LEN = 4.
module tb_cache_mem_arbiter;
    localparam logic [31:0] D_ADDR  = 32'h0000_1D00;
    localparam logic [31:0] I_ADDR  = 32'h0000_2E00;
    localparam logic [31:0] D_WDATA = 32'hDDDD_0001;
    localparam logic [31:0] I_WDATA = 32'hEEEE_0002;
    localparam int NV = 38;

    // in  = {d_req, i_req, wen, d_wlast, mem_addr_ok, mem_data_ok}
    // ctl = {mem_req, d_addr_ok, d_data_ok, i_addr_ok, i_data_ok, mem_wen, wlast}
    // own = 0 bus idle, 1 D muxed, 2 I muxed
    typedef struct {
        logic [5:0]  in;
        logic [31:0] rdata;
        logic [6:0]  ctl;
        logic [1:0]  own;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [NV];

    cache_mem_arbiter_if d_bus ();
    cache_mem_arbiter_if i_bus ();
    cache_mem_arbiter_if mem_bus ();

    cache_mem_arbiter #(.BURST_LEN(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .d_port (d_bus),
        .i_port (i_bus),
        .mem    (mem_bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] in, input logic [31:0] rd,
                                input logic [6:0] ctl, input logic [1:0] own);
        vec_t v;
        v.in = in; v.rdata = rd; v.ctl = ctl; v.own = own;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        d_bus.rq.req     = v.in[5];
        i_bus.rq.req     = v.in[4];
        d_bus.rq.wen     = v.in[3];
        i_bus.rq.wen     = v.in[3];
        d_bus.rq.wlast   = v.in[2];
        mem_bus.rsp.addr_ok = v.in[1];
        mem_bus.rsp.data_ok = v.in[0];
        mem_bus.rsp.rdata   = v.rdata;
    endtask

    task automatic check(input string nm, input logic [6:0] ec, input logic [1:0] own,
                         input logic [31:0] rd);
        logic [6:0]  ac;
        logic [31:0] ea;
        logic [31:0] ew;
        ac = {mem_bus.rq.req, d_bus.rsp.addr_ok, d_bus.rsp.data_ok,
              i_bus.rsp.addr_ok, i_bus.rsp.data_ok, mem_bus.rq.wen, mem_bus.rq.wlast};
        ea = (own == 2'd1) ? D_ADDR  : (own == 2'd2) ? I_ADDR  : 32'h0;
        ew = (own == 2'd1) ? D_WDATA : (own == 2'd2) ? I_WDATA : 32'h0;
        n_cmp++;
        if (ac !== ec) begin
            n_bad++;
            $display("FAIL %s ctl got %b want %b", nm, ac, ec);
        end
        n_cmp++;
        if (mem_bus.rq.addr !== ea || mem_bus.rq.wdata !== ew) begin
            n_bad++;
            $display("FAIL %s bus addr/wdata got %h/%h want %h/%h", nm,
                     mem_bus.rq.addr, mem_bus.rq.wdata, ea, ew);
        end
        n_cmp++;
        if (d_bus.rsp.rdata !== rd || i_bus.rsp.rdata !== rd) begin
            n_bad++;
            $display("FAIL %s rdata got %h/%h want %h", nm, d_bus.rsp.rdata, i_bus.rsp.rdata, rd);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            @(posedge clk);
            #1 apply(vecs[k]);
            #3 check($sformatf("vec%0d", k), vecs[k].ctl, vecs[k].own, vecs[k].rdata);
        end
    endtask

    initial begin
        // D read burst with I waiting; tie after reset goes to D under either policy
        vecs[0]  = mk(6'b110010, 32'h0,  7'b0000000, 2'd0);
        vecs[1]  = mk(6'b110010, 32'h0,  7'b1100000, 2'd1);
        vecs[2]  = mk(6'b110011, 32'h11, 7'b1110000, 2'd1);
        vecs[3]  = mk(6'b110011, 32'h22, 7'b1110000, 2'd1);
        vecs[4]  = mk(6'b110011, 32'h33, 7'b1110000, 2'd1);
        vecs[5]  = mk(6'b110011, 32'h44, 7'b0010000, 2'd1);
        vecs[6]  = mk(6'b010010, 32'h0,  7'b0000000, 2'd0);
        // I burst stalled 5 cycles after beat 2 while D requests
        vecs[7]  = mk(6'b010010, 32'h0,  7'b1001000, 2'd2);
        vecs[8]  = mk(6'b010011, 32'h55, 7'b1001100, 2'd2);
        vecs[9]  = mk(6'b100011, 32'h66, 7'b0000100, 2'd2);
        vecs[10] = mk(6'b100010, 32'h0,  7'b0000000, 2'd2);
        vecs[11] = mk(6'b100010, 32'h0,  7'b0000000, 2'd2);
        vecs[12] = mk(6'b100010, 32'h0,  7'b0000000, 2'd2);
        vecs[13] = mk(6'b100010, 32'h0,  7'b0000000, 2'd2);
        vecs[14] = mk(6'b110010, 32'h0,  7'b1001000, 2'd2);
        vecs[15] = mk(6'b110011, 32'h77, 7'b1001100, 2'd2);
        vecs[16] = mk(6'b100011, 32'h88, 7'b0000100, 2'd2);
        // spurious data_ok in IDLE, then a write burst with data 3 cycles behind addr
        vecs[17] = mk(6'b100011, 32'hBAD0, 7'b0000000, 2'd0);
        vecs[18] = mk(6'b101010, 32'h0,  7'b1100010, 2'd1);
        vecs[19] = mk(6'b101010, 32'h0,  7'b1100010, 2'd1);
        vecs[20] = mk(6'b101010, 32'h0,  7'b1100010, 2'd1);
        vecs[21] = mk(6'b101111, 32'h0,  7'b1110011, 2'd1);
        vecs[22] = mk(6'b101111, 32'h0,  7'b0010011, 2'd1);
        vecs[23] = mk(6'b000011, 32'h0,  7'b0010000, 2'd1);
        vecs[24] = mk(6'b000011, 32'h0,  7'b0010000, 2'd1);
        vecs[25] = mk(6'b000010, 32'h0,  7'b0000000, 2'd0);
        vecs[26] = mk(6'b000011, 32'hBAD1, 7'b0000000, 2'd0);
        // D burst to be cut by reset after 2 addr / 1 data beats
        vecs[27] = mk(6'b100010, 32'h0,  7'b0000000, 2'd0);
        vecs[28] = mk(6'b100010, 32'h0,  7'b1100000, 2'd1);
        vecs[29] = mk(6'b100011, 32'h99, 7'b1110000, 2'd1);
        // after reset: fresh D burst, then a tie with last owner D
        vecs[30] = mk(6'b100010, 32'h0,  7'b0000000, 2'd0);
        vecs[31] = mk(6'b100010, 32'h0,  7'b1100000, 2'd1);
        vecs[32] = mk(6'b100011, 32'hA1, 7'b1110000, 2'd1);
        vecs[33] = mk(6'b100011, 32'hA2, 7'b1110000, 2'd1);
        vecs[34] = mk(6'b100011, 32'hA3, 7'b1110000, 2'd1);
        vecs[35] = mk(6'b100011, 32'hA4, 7'b0010000, 2'd1);
        vecs[36] = mk(6'b110010, 32'h0,  7'b0000000, 2'd0);
`ifdef CACHE_ARB_RR_EN
        vecs[37] = mk(6'b110010, 32'h0,  7'b1001000, 2'd2);
`else
        vecs[37] = mk(6'b110010, 32'h0,  7'b1100000, 2'd1);
`endif

        d_bus.rq.addr  = D_ADDR;
        d_bus.rq.wdata = D_WDATA;
        i_bus.rq.addr  = I_ADDR;
        i_bus.rq.wdata = I_WDATA;
        i_bus.rq.wlast = 1'b0;
        apply(mk(6'b000000, 32'h5A5A_5A5A, 7'b0, 2'd0));

        repeat (2) @(posedge clk);
        #1 check("reset_state", 7'b0000000, 2'd0, 32'h5A5A_5A5A);
        @(negedge clk);
        reset = 1'b1;

        run_range(0, 29);

        @(posedge clk);
        #1 apply(mk(6'b100010, 32'h0, 7'b0, 2'd0));
        #1 check("pre_reset", 7'b1100000, 2'd1, 32'h0);
        reset = 1'b0;
        #1 check("async_reset", 7'b0000000, 2'd0, 32'h0);
        d_bus.rq.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_range(30, NV - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
